fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 62 ++++++
 rtl/fetch_queue.sv | 128 ++++++++++++
 tb/tb_fetch_queue.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared definitions for the instruction fetch queue.
//   FQ_WIDTH  : default instruction byte-address width
//   FQ_PC_INC : fetch PC advance per accepted request (bytes)
//   fq_state_e: fetch FSM states (FETCH issues requests, STALL holds the PC)
package fetch_queue_pkg;

  localparam int unsigned FQ_WIDTH  = 12;
  localparam int unsigned FQ_PC_INC = 4;

  typedef enum logic {
    FETCH = 1'b0,
    STALL = 1'b1
  } fq_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry storage for fetched {pc, instr} words.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             synchronous flush of all entries
//   wr_en, wr_data  enqueue request and payload
//   rd_en           dequeue of the head entry
//   rd_data         head entry payload (valid while !empty)
//   count, empty    occupancy
// Pointers carry one extra wrap bit: equal pointers mean empty, differing
// wrap bits with equal index bits mean full.
module fetch_fifo #(
  parameter int unsigned DW    = 44,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          do_rd;
  logic          do_wr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign do_rd = rd_en && !empty;
  // A write into a full queue is allowed when the head leaves the same cycle.
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !clr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a small decoupling queue.
// Ports:
//   i_clk, i_rst_n                clock, asynchronous active-low reset
//   o_IcacheAddr, o_IcacheReq     fetch request to the I-cache
//   i_IcacheData                  returned word, one cycle after a request
//   i_redirect, i_redirect_pc     flush and restart fetch at a new PC
//   o_valid, o_instr, o_pc        queue head towards decode
//   i_ready                       decode accepts the head
//   o_count                       occupied queue entries
// Build option: define FETCH_BYPASS_EN to forward an arriving word straight
// to the head outputs when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned      WIDTH    = FQ_WIDTH,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  output logic [WIDTH-1:0]         o_IcacheAddr,
  output logic                     o_IcacheReq,
  input  logic [31:0]              i_IcacheData,
  input  logic                     i_redirect,
  input  logic [WIDTH-1:0]         i_redirect_pc,
  output logic                     o_valid,
  output logic [31:0]              o_instr,
  output logic [WIDTH-1:0]         o_pc,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned  CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]  DEPTH_V = (CW+1)'(DEPTH);

  fq_state_e          state;
  fq_state_e          state_next;
  logic [WIDTH-1:0]   pc;
  logic [WIDTH-1:0]   req_pc;
  logic               in_flight;
  logic               req;
  logic               deq;
  logic               space;
  logic [CW:0]        occ;
  logic               byp_fwd;

  logic               q_empty;
  logic [CW-1:0]      q_count;
  logic [WIDTH+31:0]  q_head;
  logic               q_wr;
  logic               q_rd;

  fetch_fifo #(
    .DW    (WIDTH + 32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .clr     (i_redirect),
    .wr_en   (q_wr),
    .wr_data ({req_pc, i_IcacheData}),
    .rd_en   (q_rd),
    .rd_data (q_head),
    .count   (q_count),
    .empty   (q_empty)
  );

`ifdef FETCH_BYPASS_EN
  assign byp_fwd = in_flight && q_empty;
`else
  assign byp_fwd = 1'b0;
`endif

  assign o_valid = !q_empty || byp_fwd;
  assign o_instr = byp_fwd ? i_IcacheData : q_head[31:0];
  assign o_pc    = byp_fwd ? req_pc : q_head[WIDTH+31:32];
  assign o_count = q_count;

  assign deq  = o_valid && i_ready;
  assign q_rd = !q_empty && i_ready && !i_redirect;
  // A forwarded word taken by decode never occupies an entry.
  assign q_wr = in_flight && !i_redirect && !(byp_fwd && i_ready);

  // Space is judged on occupancy after this cycle's arrival and dequeue.
  assign occ   = {1'b0, q_count} + {{CW{1'b0}}, in_flight};
  assign space = deq ? (occ <= DEPTH_V) : (occ < DEPTH_V);

  always_comb begin
    state_next = state;
    req        = 1'b0;
    unique case (state)
      FETCH: begin
        if (space) req = 1'b1;
        else       state_next = STALL;
      end
      STALL: begin
        if (space) state_next = FETCH;
      end
    endcase
    if (i_redirect) begin
      state_next = FETCH;
      req        = 1'b0;
    end
    if (!i_rst_n) req = 1'b0;
  end

  assign o_IcacheReq  = req;
  assign o_IcacheAddr = pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      req_pc    <= RESET_PC;
      in_flight <= 1'b0;
    end else begin
      state     <= state_next;
      in_flight <= req;
      if (i_redirect) begin
        pc <= i_redirect_pc;
      end else if (req) begin
        pc     <= pc + WIDTH'(FQ_PC_INC);
        req_pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed and randomized checks of fetch_queue against a
// queue-based reference model. Honours FETCH_BYPASS_EN when defined.
module tb_fetch_queue;

  localparam int unsigned WIDTH    = 12;
  localparam int unsigned DEPTH    = 4;
  localparam logic [11:0] RESET_PC = 12'h000;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [11:0] o_IcacheAddr;
  logic        o_IcacheReq;
  logic [31:0] i_IcacheData;
  logic        i_redirect;
  logic [11:0] i_redirect_pc;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [11:0] o_pc;
  logic        i_ready;
  logic [2:0]  o_count;

  fetch_queue #(
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .o_IcacheAddr  (o_IcacheAddr),
    .o_IcacheReq   (o_IcacheReq),
    .i_IcacheData  (i_IcacheData),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_valid       (o_valid),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .i_ready       (i_ready),
    .o_count       (o_count)
  );

  always #5 i_clk = ~i_clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: fetch PC, outstanding request, queued PCs, stall flag.
  logic [11:0] m_pc;
  bit          m_if;
  logic [11:0] m_if_addr;
  logic [11:0] m_q[$];
  bit          m_stall;

  logic        s_req;
  logic [11:0] s_addr;

  function automatic logic [31:0] word_of(input logic [11:0] a);
    return {8'hC3, 12'h000, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = RESET_PC;
    m_if      = 1'b0;
    m_if_addr = RESET_PC;
    m_q.delete();
    m_stall   = 1'b0;
  endtask

  // One clock: compare at the falling edge, advance the model, then play
  // the memory role for whatever the DUT requested.
  task automatic step();
    int          cnt;
    int          occ;
    bit          byp;
    bit          vld;
    bit          deq;
    bit          space;
    bit          req;
    logic [11:0] hpc;
    @(negedge i_clk);
    cnt   = m_q.size();
    byp   = BYP && m_if && (cnt == 0);
    vld   = (cnt != 0) || byp;
    hpc   = (cnt != 0) ? m_q[0] : m_if_addr;
    deq   = vld && i_ready;
    occ   = cnt + int'(m_if) - int'(deq);
    space = occ < int'(DEPTH);
    req   = !m_stall && space && !i_redirect;

    check("count", 64'(o_count), 64'(cnt));
    check("req", 64'(o_IcacheReq), 64'(req));
    if (req) check("addr", 64'(o_IcacheAddr), 64'(m_pc));
    check("valid", 64'(o_valid), 64'(vld));
    if (vld) begin
      check("pc", 64'(o_pc), 64'(hpc));
      check("instr", 64'(o_instr), 64'(word_of(hpc)));
    end
    s_req  = o_IcacheReq;
    s_addr = o_IcacheAddr;

    if (i_redirect) begin
      m_q.delete();
      m_if    = 1'b0;
      m_pc    = i_redirect_pc;
      m_stall = 1'b0;
    end else begin
      if (deq && cnt != 0) void'(m_q.pop_front());
      if (m_if && !(byp && i_ready)) m_q.push_back(m_if_addr);
      m_stall = !space;
      m_if    = req;
      if (req) begin
        m_if_addr = m_pc;
        m_pc      = m_pc + 12'd4;
      end
    end
    @(posedge i_clk);
    #1;
    i_IcacheData = s_req ? word_of(s_addr) : $urandom;
  endtask

  task automatic redirect_to(input logic [11:0] target);
    i_redirect    = 1'b1;
    i_redirect_pc = target;
    step();
    i_redirect    = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    i_rst_n       = 1'b0;
    i_ready       = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    i_IcacheData  = '0;
    model_reset();

    // Held in reset: nothing valid, nothing requested.
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_req", 64'(o_IcacheReq), 64'(0));
    check("rst_count", 64'(o_count), 64'(0));
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // Free-running fetch from RESET_PC.
    i_ready = 1'b1;
    repeat (8) step();

    // Decode stalled: queue saturates, fetch stops, nothing is lost.
    redirect_to(12'h000);
    i_ready = 1'b0;
    repeat (10) step();
    check("sat_count", 64'(o_count), 64'(4));
    check("sat_req", 64'(o_IcacheReq), 64'(0));
    i_ready = 1'b1;
    repeat (8) step();

    // Redirect with three queued entries and one request outstanding.
    redirect_to(12'h000);
    i_ready = 1'b0;
    repeat (4) step();
    check("pre_redir_count", 64'(o_count), 64'(3));
    redirect_to(12'h100);
    check("redir_valid", 64'(o_valid), 64'(0));
    check("redir_count", 64'(o_count), 64'(0));
    check("redir_addr", 64'(o_IcacheAddr), 64'(12'h100));
    i_ready = 1'b1;
    repeat (6) step();

    // Full queue: dequeue and redirect together empties it.
    i_ready = 1'b0;
    repeat (8) step();
    check("full_count", 64'(o_count), 64'(4));
    i_ready = 1'b1;
    redirect_to(12'h040);
    check("full_redir_count", 64'(o_count), 64'(0));
    repeat (4) step();

    // PC wrap at the top of the address space.
    redirect_to(12'hFF4);
    repeat (10) begin
      i_ready = ($urandom_range(3) != 0);
      step();
    end

    // Asynchronous reset pulse mid-fetch.
    i_ready = 1'b1;
    repeat (3) step();
    #2;
    i_rst_n = 1'b0;
    #1;
    check("async_valid", 64'(o_valid), 64'(0));
    check("async_req", 64'(o_IcacheReq), 64'(0));
    check("async_count", 64'(o_count), 64'(0));
    model_reset();
    i_rst_n = 1'b1;
    repeat (5) step();

    // Randomized traffic with occasional redirects.
    repeat (300) begin
      i_ready = ($urandom_range(3) != 0);
      if ($urandom_range(19) == 0) begin
        r = $urandom;
        redirect_to(r[11:0] & 12'hFFC);
      end else begin
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
